ysyx_25040129_trap_seq: RTL
===========================

# ysyx_25040129_trap_seq

Trap/return sequencer sitting directly upstream of the CSR register file's single write port. It accepts `ecall` (trap entry) and `mret` requests from the execute stage and sequences the required multi-register CSR updates through the single-port CSR interface, one register per cycle. It then issues a one-cycle PC redirect to the fetch stage. While idle it passes the execute stage's ordinary CSR reads and writes straight through to the CSR file.

## Interface
- `CSR_DIG`, 12: CSR address width.
- `A_MSTATUS`, 12'h300: mstatus address.
- `A_MTVEC`, 12'h305: mtvec address.
- `A_MEPC`, 12'h341: mepc address.

Ports:
- `clk`  in  1  sole clock; all state updates on posedge.
- `rst`  in  1  reset, synchronous, active-low (`rst`=0 resets on the next posedge).
- `req_valid`  in  1  execute stage presents a trap/return request.
- `req_ready`  out  1  high only in IDLE; request accepted when `req_valid & req_ready`.
- `req_is_mret`  in  1  1 = mret, 0 = ecall trap entry.
- `req_pc`  in  32  PC of the requesting instruction.
- `exu_csr_write`  in  1  execute-stage CSR write enable (csrrw etc.).
- `exu_csr_waddr`  in  CSR_DIG  execute-stage write address.
- `exu_csr_wdata`  in  32  execute-stage write data.
- `exu_csr_raddr`  in  CSR_DIG  execute-stage read address.
- `exu_csr_rdata`  out  32  read data returned to execute stage (= `csr_out`, always).
- `csr_write`  out  1  CSR file write enable.
- `csr_write_addr`  out  CSR_DIG  CSR file write address.
- `csr_read_addr`  out  CSR_DIG  CSR file read address.
- `csr_data`  out  32  CSR file write data.
- `csr_out`  in  32  CSR file combinational read data.
- `redirect_valid`  out  1  one-cycle pulse: fetch must jump to `redirect_pc`.
- `redirect_pc`  out  32  redirect target.
- `busy`  out  1  state != IDLE.

## Operation
- FSM states: IDLE, E_EPC, E_STAT, E_VEC, R_STAT, R_EPC. State is held in a register; all CSR-port outputs are combinational from state plus the latched request.
- IDLE:
  - `req_ready`=1.
  - CSR port mirrors the execute stage: `csr_write`=`exu_csr_write`, `csr_write_addr`=`exu_csr_waddr`, `csr_data`=`exu_csr_wdata`, `csr_read_addr`=`exu_csr_raddr`.
  - On accept: latch `pc_q`={`req_pc`[31:2],2'b00}. Go to E_EPC if `req_is_mret`=0, otherwise R_STAT.
- Outside IDLE the sequencer owns the CSR port; `exu_csr_write` is ignored (the execute stage stalls on `busy`).
- E_EPC: write `A_MEPC` ← `pc_q`. Next state E_STAT.
- E_STAT: read `A_MSTATUS` and write `A_MSTATUS` in the same cycle with:
  - MPIE(bit7) ← old MIE(bit3);
  - MIE ← 0;
  - MPP[12:11] ← 2'b11;
  - all other bits preserved.
  - Next state E_VEC.
- E_VEC: read `A_MTVEC`. Assert `redirect_valid`=1, `redirect_pc`={`csr_out`[31:2],2'b00}. No write. Next state IDLE.
- R_STAT: read and write `A_MSTATUS` with:
  - MIE ← old MPIE;
  - MPIE ← 1;
  - MPP ← 2'b11 (M-mode only core);
  - others preserved.
  - Next state R_EPC.
- R_EPC: read `A_MEPC`. Assert `redirect_valid`=1, `redirect_pc`={`csr_out`[31:2],2'b00}. Next state IDLE.
- mcause is not written; the CSR file reports cause 11 (M-mode ecall) constantly.

## Timing
- Reset: state=IDLE, `pc_q`=0, `redirect_valid`=0, `redirect_pc`=0, `busy`=0, `req_ready`=1. The CSR port follows the execute stage's inputs.
- Trap latency: accept at cycle 0; mepc write at cycle 1; mstatus write at cycle 2; redirect pulse at cycle 3; `req_ready` high again at cycle 4.
- Mret latency: accept at cycle 0; mstatus write at cycle 1; redirect pulse at cycle 2; ready at cycle 3.
- Exactly one `csr_write` per sequencer write state. `redirect_valid` is high for exactly one cycle per request and never in IDLE.
- Request with `req_valid` low or not ready: no state change, no latch.
- Back-to-back: a request held through the busy period is accepted on the first IDLE cycle, with no bubble beyond that.
- `rst`=0 mid-sequence: return to IDLE on that edge. No further sequencer writes, no redirect, and the pending request is dropped.
- Simultaneous `exu_csr_write` and accept in IDLE: the execute-stage write goes through in that cycle. The sequence begins next cycle.

## Test plan
- Trap: mstatus=0x8, mtvec=0x80000201, accept ecall with `req_pc`=0x80000104.
  - Cycle 1: write mepc=0x80000104.
  - Cycle 2: write mstatus=0x1880.
  - Cycle 3: redirect 0x80000200, one-cycle pulse.
- Mret: mstatus=0x1880, mepc=0x80000108.
  - Cycle 1: write mstatus=0x1888.
  - Cycle 2: redirect 0x80000108.
  - Cycle 3: `req_ready`=1.
- Pass-through: in IDLE, exu write of mtvec=0x80001000, then exu read of mtvec returns 0x80001000. While busy, an exu write of mepc=0x1234 is not issued to the CSR port.
- Back-to-back: ecall immediately followed by mret, with `req_valid` held. Required: 3+1-cycle spacing and the correct two redirects (mtvec target, then the stored mepc).
- Reset at cycle 2 of a trap: mstatus unchanged, no redirect, `busy`=0 next cycle.
- Unaligned inputs: `req_pc`=0x80000106 gives mepc=0x80000104; mtvec=0x80000003 gives redirect 0x80000000.

Source files
------------

// File: rtl/ysyx_25040129_trap_seq_if.sv
// Bus bundle between the execute stage, the trap sequencer and the CSR file.
// The slave modport is the sequencer's view. The master modport is the surrounding pipeline and CSR file.
interface ysyx_25040129_trap_seq_if #(
  parameter int CSR_DIG = 12
);
  logic                req_valid;
  logic                req_ready;
  logic                req_is_mret;
  logic [31:0]         req_pc;
  logic                exu_csr_write;
  logic [CSR_DIG-1:0]  exu_csr_waddr;
  logic [31:0]         exu_csr_wdata;
  logic [CSR_DIG-1:0]  exu_csr_raddr;
  logic [31:0]         exu_csr_rdata;
  logic                csr_write;
  logic [CSR_DIG-1:0]  csr_write_addr;
  logic [CSR_DIG-1:0]  csr_read_addr;
  logic [31:0]         csr_data;
  logic [31:0]         csr_out;
  logic                redirect_valid;
  logic [31:0]         redirect_pc;
  logic                busy;

  modport master (
    output req_valid, req_is_mret, req_pc,
    output exu_csr_write, exu_csr_waddr, exu_csr_wdata, exu_csr_raddr,
    input  req_ready, exu_csr_rdata,
    input  csr_write, csr_write_addr, csr_read_addr, csr_data,
    output csr_out,
    input  redirect_valid, redirect_pc, busy
  );

  modport slave (
    input  req_valid, req_is_mret, req_pc,
    input  exu_csr_write, exu_csr_waddr, exu_csr_wdata, exu_csr_raddr,
    output req_ready, exu_csr_rdata,
    output csr_write, csr_write_addr, csr_read_addr, csr_data,
    input  csr_out,
    output redirect_valid, redirect_pc, busy
  );
endinterface

// File: rtl/ysyx_25040129_trap_seq.sv
// Trap-entry / mret sequencer. It drives the single-port CSR file one register per cycle and then redirects fetch.
// While idle, it passes execute-stage CSR traffic straight through.
module ysyx_25040129_trap_seq #(
  parameter int                 CSR_DIG   = 12,
  parameter logic [CSR_DIG-1:0] A_MSTATUS = 12'h300,
  parameter logic [CSR_DIG-1:0] A_MTVEC   = 12'h305,
  parameter logic [CSR_DIG-1:0] A_MEPC    = 12'h341
) (
  input logic                    clk,
  input logic                    rst,
  ysyx_25040129_trap_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_E_EPC,
    S_E_STAT,
    S_E_VEC,
    S_R_STAT,
    S_R_EPC
  } state_t;

  state_t      state_q, state_d, state_eff;
  logic [31:0] pc_q, pc_d;
  logic [31:0] stat_trap, stat_ret;

  // While reset is asserted, the outputs already behave as IDLE, so no sequencer write or redirect leaks out.
  assign state_eff = rst ? state_q : S_IDLE;

  assign bus.exu_csr_rdata = bus.csr_out;

  always_comb begin
    stat_trap        = bus.csr_out;
    stat_trap[7]     = bus.csr_out[3];
    stat_trap[3]     = 1'b0;
    stat_trap[12:11] = 2'b11;
    stat_ret         = bus.csr_out;
    stat_ret[3]      = bus.csr_out[7];
    stat_ret[7]      = 1'b1;
    stat_ret[12:11]  = 2'b11;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pc_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    pc_d               = pc_q;
    bus.req_ready      = 1'b0;
    bus.busy           = 1'b1;
    bus.csr_write      = 1'b0;
    bus.csr_write_addr = '0;
    bus.csr_read_addr  = '0;
    bus.csr_data       = 32'h0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    case (state_eff)
      S_IDLE: begin
        bus.req_ready      = 1'b1;
        bus.busy           = 1'b0;
        bus.csr_write      = bus.exu_csr_write;
        bus.csr_write_addr = bus.exu_csr_waddr;
        bus.csr_data       = bus.exu_csr_wdata;
        bus.csr_read_addr  = bus.exu_csr_raddr;
        if (bus.req_valid) begin
          pc_d    = {bus.req_pc[31:2], 2'b00};
          state_d = bus.req_is_mret ? S_R_STAT : S_E_EPC;
        end
      end
      S_E_EPC: begin
        bus.csr_write      = 1'b1;
        bus.csr_write_addr = A_MEPC;
        bus.csr_read_addr  = A_MEPC;
        bus.csr_data       = pc_q;
        state_d            = S_E_STAT;
      end
      S_E_STAT: begin
        bus.csr_write      = 1'b1;
        bus.csr_write_addr = A_MSTATUS;
        bus.csr_read_addr  = A_MSTATUS;
        bus.csr_data       = stat_trap;
        state_d            = S_E_VEC;
      end
      S_E_VEC: begin
        bus.csr_read_addr  = A_MTVEC;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = {bus.csr_out[31:2], 2'b00};
        state_d            = S_IDLE;
      end
      S_R_STAT: begin
        bus.csr_write      = 1'b1;
        bus.csr_write_addr = A_MSTATUS;
        bus.csr_read_addr  = A_MSTATUS;
        bus.csr_data       = stat_ret;
        state_d            = S_R_EPC;
      end
      S_R_EPC: begin
        bus.csr_read_addr  = A_MEPC;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = {bus.csr_out[31:2], 2'b00};
        state_d            = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
